// File: rtl/hilo_pkg.sv
// HI/LO shared types, widths and op decode; HILO_MSUB_EN enables the Msub path.
// Pure declarations: no latency, no backpressure.
package hilo_pkg;

    localparam int HILO_DATA_W = 32;
    localparam int HILO_ACC_W  = 2 * HILO_DATA_W;

`ifdef HILO_MSUB_EN
    localparam bit HILO_MSUB_ON = 1'b1;
`else
    localparam bit HILO_MSUB_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        HILO_HOLD,
        HILO_LOAD,
        HILO_ADD,
        HILO_SUB
    } hilo_op_t;

    // Load beats accumulate, accumulate beats subtract.
    function automatic hilo_op_t hilo_decode(
        input logic write_en,
        input logic madd,
        input logic msub
    );
        hilo_op_t op;
        op = HILO_HOLD;
        if (write_en) begin
            op = HILO_LOAD;
        end else if (madd) begin
            op = HILO_ADD;
        end else if (msub && HILO_MSUB_ON) begin
            op = HILO_SUB;
        end
        return op;
    endfunction

endpackage

// File: rtl/hilo_accumulator.sv
// Combinational full-width add/subtract of the HI/LO state and operand (subtract only with HILO_MSUB_EN).
// Zero latency, no backpressure; non-arithmetic ops pass the state through.
module hilo_accumulator
    import hilo_pkg::*;
#(
    parameter int ACC_W = HILO_ACC_W
) (
    input  hilo_op_t         op,
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] operand,
    output logic [ACC_W-1:0] result
);

    always_comb begin
        result = acc;
        case (op)
            HILO_ADD: result = acc + operand;
`ifdef HILO_MSUB_EN
            HILO_SUB: result = acc - operand;
`endif
            default:  result = acc;
        endcase
    end

endmodule

// File: rtl/hi_lo_register_file.sv
// MIPS HI/LO register pair with load, 64-bit Madd and (with HILO_MSUB_EN) Msub.
// One-cycle update, no bypass, one op per clock; never stalls.
module hi_lo_register_file
    import hilo_pkg::*;
#(
    parameter int DATA_W = HILO_DATA_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              WriteEn,
    input  logic              Madd,
    input  logic              Msub,
    input  logic [DATA_W-1:0] WriteHiData,
    input  logic [DATA_W-1:0] WriteLoData,
    output logic [DATA_W-1:0] ReadHi,
    output logic [DATA_W-1:0] ReadLo
);

    localparam int ACC_W = 2 * DATA_W;

    hilo_op_t         op;
    logic [ACC_W-1:0] operand;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] arith_result;

    assign op      = hilo_decode(WriteEn, Madd, Msub);
    assign operand = {WriteHiData, WriteLoData};

    hilo_accumulator #(
        .ACC_W (ACC_W)
    ) u_acc (
        .op      (op),
        .acc     (acc_q),
        .operand (operand),
        .result  (arith_result)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_q <= '0;
        end else begin
            case (op)
                HILO_LOAD: acc_q <= operand;
                HILO_ADD,
                HILO_SUB:  acc_q <= arith_result;
                default:   acc_q <= acc_q;
            endcase
        end
    end

    // Outputs come straight from the flops; write data never reaches them combinationally.
    assign ReadHi = acc_q[ACC_W-1:DATA_W];
    assign ReadLo = acc_q[DATA_W-1:0];

endmodule

// File: tb/tb_hi_lo_register_file.sv
// Directed bench for hi_lo_register_file; Msub expectations follow HILO_MSUB_EN.
module tb_hi_lo_register_file;

`ifdef HILO_MSUB_EN
    localparam bit MSUB_ON = 1'b1;
`else
    localparam bit MSUB_ON = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        WriteEn;
    logic        Madd;
    logic        Msub;
    logic [31:0] WriteHiData;
    logic [31:0] WriteLoData;
    logic [31:0] ReadHi;
    logic [31:0] ReadLo;

    int checks = 0;
    int errors = 0;

    hi_lo_register_file #(.DATA_W(32)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .WriteEn     (WriteEn),
        .Madd        (Madd),
        .Msub        (Msub),
        .WriteHiData (WriteHiData),
        .WriteLoData (WriteLoData),
        .ReadHi      (ReadHi),
        .ReadLo      (ReadLo)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic ma, input logic ms, input logic [63:0] opnd);
        WriteEn     = we;
        Madd        = ma;
        Msub        = ms;
        WriteHiData = opnd[63:32];
        WriteLoData = opnd[31:0];
    endtask

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    // Apply one op for exactly one edge, then return controls to idle.
    task automatic apply(input logic we, input logic ma, input logic ms, input logic [63:0] opnd);
        drive(we, ma, ms, opnd);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    initial begin
        Rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 64'h0);

        #3 Rst_n = 1'b0;
        #1 check("reset_async", {ReadHi, ReadLo}, 64'h0);
        cycle();
        check("reset_held", {ReadHi, ReadLo}, 64'h0);
        @(negedge Clk) Rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 64'hDEAD_BEEF_1234_5678);
        cycle();
        cycle();
        check("idle_hold", {ReadHi, ReadLo}, 64'h0);

        apply(1'b0, 1'b1, 1'b0, 64'hFF00FF00_00FF00FF);
        check("madd_first", {ReadHi, ReadLo}, 64'hFF00FF00_00FF00FF);
        apply(1'b0, 1'b1, 1'b0, 64'h00FF00FF_FF00FF00);
        check("madd_second", {ReadHi, ReadLo}, 64'hFFFFFFFF_FFFFFFFF);

        apply(1'b1, 1'b0, 1'b0, 64'h00000000_FFFFFFFF);
        check("load_lo_ones", {ReadHi, ReadLo}, 64'h00000000_FFFFFFFF);
        apply(1'b0, 1'b1, 1'b0, 64'h00000000_00000001);
        check("madd_carry", {ReadHi, ReadLo}, 64'h00000001_00000000);

        apply(1'b1, 1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFFF);
        apply(1'b0, 1'b1, 1'b0, 64'h1);
        check("madd_wrap", {ReadHi, ReadLo}, 64'h0);

        apply(1'b1, 1'b0, 1'b0, 64'h00000020_FFFFFFFF);
        check("load", {ReadHi, ReadLo}, 64'h00000020_FFFFFFFF);
        apply(1'b0, 1'b0, 1'b1, 64'h00000000_00000400);
        check("msub", {ReadHi, ReadLo},
              MSUB_ON ? 64'h00000020_FFFFFBFF : 64'h00000020_FFFFFFFF);

        apply(1'b1, 1'b0, 1'b0, 64'h00000001_00000000);
        apply(1'b0, 1'b0, 1'b1, 64'h1);
        check("msub_borrow", {ReadHi, ReadLo},
              MSUB_ON ? 64'h00000000_FFFFFFFF : 64'h00000001_00000000);

        apply(1'b1, 1'b1, 1'b1, 64'h00000005_00000006);
        check("prio_load", {ReadHi, ReadLo}, 64'h00000005_00000006);
        apply(1'b1, 1'b0, 1'b0, 64'h00000000_00000010);
        apply(1'b0, 1'b1, 1'b1, 64'h00000000_00000001);
        check("prio_madd", {ReadHi, ReadLo}, 64'h00000000_00000011);

        drive(1'b0, 1'b0, 1'b0, 64'hAAAA5555_5555AAAA);
        cycle();
        check("hold_data", {ReadHi, ReadLo}, 64'h00000000_00000011);

        // Held Madd accumulates each edge; reset mid-run clears at once.
        apply(1'b1, 1'b0, 1'b0, 64'h0);
        drive(1'b0, 1'b1, 1'b0, 64'h00000001_00000003);
        cycle();
        check("held_madd_1", {ReadHi, ReadLo}, 64'h00000001_00000003);
        cycle();
        check("held_madd_2", {ReadHi, ReadLo}, 64'h00000002_00000006);
        #3 Rst_n = 1'b0;
        #1 check("reset_in_madd", {ReadHi, ReadLo}, 64'h0);
        cycle();
        check("reset_madd_held", {ReadHi, ReadLo}, 64'h0);
        @(negedge Clk) Rst_n = 1'b1;
        cycle();
        check("restart_madd", {ReadHi, ReadLo}, 64'h00000001_00000003);
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        cycle();
        check("post_restart_hold", {ReadHi, ReadLo}, 64'h00000001_00000003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
